// File: rtl/change_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// change_dispense_ctrl
//
// Pays out a latched change amount one coin at a time through a hopper
// request/acknowledge handshake. Each coin is the largest denomination
// (10, 5, 1) that fits in the amount still owed and is still in stock.
// A per-denomination inventory is kept. If change cannot be paid in full,
// the shortfall flag is raised.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   start         request a payout (accepted only when idle)
//   changeAmount  amount to return, latched together with start
//   coinAck       hopper released one coin (meaningful only while coinReq=1)
//   refill        reload all inventories to INITx (accepted only when idle)
//   busy          payout in progress, from the cycle after start through DONE
//   coinReq       request one coin of type coinSel; held until coinAck
//   coinSel       0 = 1-unit, 1 = 5-unit, 2 = 10-unit
//   done          one-cycle pulse when a payout finishes
//   shortfall     last payout ended with change still owed (sticky)
//   remaining     change still owed
//   cnt10/5/1     current coin inventory per denomination
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module change_dispense_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned INIT10 = 20,
    parameter int unsigned INIT5  = 20,
    parameter int unsigned INIT1  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] changeAmount,
    input  logic              coinAck,
    input  logic              refill,
    output logic              busy,
    output logic              coinReq,
    output logic [1:0]        coinSel,
    output logic              done,
    output logic              shortfall,
    output logic [DATA_W-1:0] remaining,
    output logic [CNT_W-1:0]  cnt10,
    output logic [CNT_W-1:0]  cnt5,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StDispense,
        StDone
    } state_e;

    localparam logic [1:0] Sel1  = 2'd0;
    localparam logic [1:0] Sel5  = 2'd1;
    localparam logic [1:0] Sel10 = 2'd2;

    localparam logic [CNT_W-1:0]  Init10 = CNT_W'(INIT10);
    localparam logic [CNT_W-1:0]  Init5  = CNT_W'(INIT5);
    localparam logic [CNT_W-1:0]  Init1  = CNT_W'(INIT1);
    localparam logic [DATA_W-1:0] Val10  = DATA_W'(10);
    localparam logic [DATA_W-1:0] Val5   = DATA_W'(5);
    localparam logic [DATA_W-1:0] Val1   = DATA_W'(1);

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               coin_req_q, coin_req_d;
    logic [1:0]         coin_sel_q, coin_sel_d;
    logic               done_q, done_d;
    logic               shortfall_q, shortfall_d;
    logic [DATA_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]   cnt10_q, cnt10_d;
    logic [CNT_W-1:0]   cnt5_q, cnt5_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    // Value of the coin currently selected; only used while dispensing.
    logic [DATA_W-1:0]  coin_value;

    always_comb begin
        unique case (coin_sel_q)
            Sel10:   coin_value = Val10;
            Sel5:    coin_value = Val5;
            default: coin_value = Val1;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        coin_req_d  = coin_req_q;
        coin_sel_d  = coin_sel_q;
        done_d      = 1'b0;
        shortfall_d = shortfall_q;
        remaining_d = remaining_q;
        cnt10_d     = cnt10_q;
        cnt5_d      = cnt5_q;
        cnt1_d      = cnt1_q;

        unique case (state_q)
            StIdle: begin
                if (refill) begin
                    cnt10_d = Init10;
                    cnt5_d  = Init5;
                    cnt1_d  = Init1;
                end
                if (start) begin
                    remaining_d = changeAmount;
                    shortfall_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = StSelect;
                end
            end

            StSelect: begin
                // Greedy choice; a denomination is eligible only when in
                // stock, so the inventory can never underflow.
                if (remaining_q == '0) begin
                    state_d = StDone;
                end else if (remaining_q >= Val10 && cnt10_q != '0) begin
                    coin_sel_d = Sel10;
                    state_d    = StDispense;
                end else if (remaining_q >= Val5 && cnt5_q != '0) begin
                    coin_sel_d = Sel5;
                    state_d    = StDispense;
                end else if (cnt1_q != '0) begin
                    coin_sel_d = Sel1;
                    state_d    = StDispense;
                end else begin
                    shortfall_d = 1'b1;
                    state_d     = StDone;
                end
            end

            StDispense: begin
                // The request register rises one edge after entry, so an
                // ack seen before the request is visible is ignored.
                if (coin_req_q && coinAck) begin
                    coin_req_d  = 1'b0;
                    remaining_d = remaining_q - coin_value;
                    unique case (coin_sel_q)
                        Sel10:   cnt10_d = cnt10_q - 1'b1;
                        Sel5:    cnt5_d  = cnt5_q - 1'b1;
                        default: cnt1_d  = cnt1_q - 1'b1;
                    endcase
                    state_d = StSelect;
                end else begin
                    coin_req_d = 1'b1;
                end
            end

            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            coin_req_q  <= 1'b0;
            coin_sel_q  <= Sel1;
            done_q      <= 1'b0;
            shortfall_q <= 1'b0;
            remaining_q <= '0;
            cnt10_q     <= Init10;
            cnt5_q      <= Init5;
            cnt1_q      <= Init1;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            coin_req_q  <= coin_req_d;
            coin_sel_q  <= coin_sel_d;
            done_q      <= done_d;
            shortfall_q <= shortfall_d;
            remaining_q <= remaining_d;
            cnt10_q     <= cnt10_d;
            cnt5_q      <= cnt5_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign busy      = busy_q;
    assign coinReq   = coin_req_q;
    assign coinSel   = coin_sel_q;
    assign done      = done_q;
    assign shortfall = shortfall_q;
    assign remaining = remaining_q;
    assign cnt10     = cnt10_q;
    assign cnt5      = cnt5_q;
    assign cnt1      = cnt1_q;

endmodule
